// File: rtl/butterfly_n.sv
// N-point butterfly stage: mirrored-pair sums/differences per runtime segment size, or sign-extending pass-through.
// Latency 1 cycle (2 when BUTTERFLY_N_PIPE2_EN is defined, adding a second register stage).
// Backpressure: valid/ready, i_ready = !o_valid || o_ready with no skid buffer; held output is stable while stalled.
module butterfly_n #(
  parameter int N  = 32,
  parameter int IW = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [1:0]             i_size,
  input  logic                   i_mode,
  input  logic [N*IW-1:0]        i_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [1:0]             o_size,
  output logic [N*(IW+1)-1:0]    o_data
);

  localparam int OW = IW + 1;
  // Largest legal size code for this N; larger requests clamp to a single N-wide segment.
  localparam logic [1:0] MAXSZ = 2'($clog2(N) - 2);

  logic [N*OW-1:0] ext;
  logic [N*OW-1:0] cand [4];
  logic [N*OW-1:0] nxt_data;
  logic [1:0]      eff_size;

  for (genvar k = 0; k < N; k++) begin : g_ext
    assign ext[k*OW +: OW] = {i_data[k*IW+IW-1], i_data[k*IW +: IW]};
  end

  // One fully wired candidate per segment size; partner Q mirrors k inside its segment.
  for (genvar sz = 0; sz < 4; sz++) begin : g_size
    localparam int S = 4 << sz;
    if (S <= N) begin : g_on
      for (genvar k = 0; k < N; k++) begin : g_smp
        localparam int P = k % S;
        localparam int Q = k - P + S - 1 - P;
        if (P < S / 2) begin : g_sum
          assign cand[sz][k*OW +: OW] = ext[k*OW +: OW] + ext[Q*OW +: OW];
        end else begin : g_dif
          assign cand[sz][k*OW +: OW] = ext[Q*OW +: OW] - ext[k*OW +: OW];
        end
      end
    end else begin : g_off
      assign cand[sz] = '0;
    end
  end

  always_comb begin
    eff_size = (i_size > MAXSZ) ? MAXSZ : i_size;
    nxt_data = i_mode ? ext : cand[eff_size];
  end

`ifdef BUTTERFLY_N_PIPE2_EN
  logic            s1_valid;
  logic [1:0]      s1_size;
  logic [N*OW-1:0] s1_data;
  logic            s1_ready;
  logic            s2_ready;

  assign s2_ready = !o_valid || o_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign i_ready  = s1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_size  <= '0;
      s1_data  <= '0;
    end else if (s1_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_size <= i_size;
        s1_data <= nxt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_size  <= '0;
      o_data  <= '0;
    end else if (s2_ready) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_size <= s1_size;
        o_data <= s1_data;
      end
    end
  end
`else
  assign i_ready = !o_valid || o_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_size  <= '0;
      o_data  <= '0;
    end else if (i_ready) begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_size <= i_size;
        o_data <= nxt_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_butterfly_n.sv
// Self-checking bench for butterfly_n: three instances (N=4, 8, 32) against a behavioural model.
module tb_butterfly_n;

`ifdef BUTTERFLY_N_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int IW = 24;
  localparam int OW = 25;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic          a_ivalid, a_iready, a_imode, a_ovalid, a_oready;
  logic [1:0]    a_isize, a_osize;
  logic [4*IW-1:0]  a_idata;
  logic [4*OW-1:0]  a_odata;
  logic          b_ivalid, b_iready, b_imode, b_ovalid, b_oready;
  logic [1:0]    b_isize, b_osize;
  logic [8*IW-1:0]  b_idata;
  logic [8*OW-1:0]  b_odata;
  logic          c_ivalid, c_iready, c_imode, c_ovalid, c_oready;
  logic [1:0]    c_isize, c_osize;
  logic [32*IW-1:0] c_idata;
  logic [32*OW-1:0] c_odata;

  butterfly_n #(.N(4), .IW(IW)) u_a (
    .clk(clk), .rst(rst), .i_valid(a_ivalid), .i_ready(a_iready), .i_size(a_isize),
    .i_mode(a_imode), .i_data(a_idata), .o_valid(a_ovalid), .o_ready(a_oready),
    .o_size(a_osize), .o_data(a_odata));
  butterfly_n #(.N(8), .IW(IW)) u_b (
    .clk(clk), .rst(rst), .i_valid(b_ivalid), .i_ready(b_iready), .i_size(b_isize),
    .i_mode(b_imode), .i_data(b_idata), .o_valid(b_ovalid), .o_ready(b_oready),
    .o_size(b_osize), .o_data(b_odata));
  butterfly_n #(.N(32), .IW(IW)) u_c (
    .clk(clk), .rst(rst), .i_valid(c_ivalid), .i_ready(c_iready), .i_size(c_isize),
    .i_mode(c_imode), .i_data(c_idata), .o_valid(c_ovalid), .o_ready(c_oready),
    .o_size(c_osize), .o_data(c_odata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint rnd_s();
    logic [23:0] v;
    v = 24'($urandom);
    case ($urandom_range(0, 7))
      0: v = 24'h7FFFFF;
      1: v = 24'h800000;
      default: ;
    endcase
    return longint'($signed(v));
  endfunction

  // Reference: segment of size S=min(4<<sz, n), sums low half, differences mirrored high half.
  function automatic void model(input int n, input longint x[32], input int sz, input bit md,
                                output longint y[32]);
    int s;
    s = 4 << sz;
    if (s > n) s = n;
    for (int k = 0; k < 32; k++) y[k] = 0;
    if (md) begin
      for (int k = 0; k < n; k++) y[k] = x[k];
    end else begin
      for (int m = 0; m < n / s; m++)
        for (int k = 0; k < s / 2; k++) begin
          y[m*s+k]       = x[m*s+k] + x[m*s+s-1-k];
          y[m*s+s-1-k]   = x[m*s+k] - x[m*s+s-1-k];
        end
    end
  endfunction

  function automatic logic [32*IW-1:0] packi(input longint x[32]);
    logic [32*IW-1:0] r;
    for (int k = 0; k < 32; k++) r[k*IW +: IW] = 24'(x[k]);
    return r;
  endfunction

  function automatic logic [32*OW-1:0] packo(input longint y[32]);
    logic [32*OW-1:0] r;
    for (int k = 0; k < 32; k++) r[k*OW +: OW] = 25'(y[k]);
    return r;
  endfunction

  task automatic xfer_c(input longint x[32], input logic [1:0] sz, input bit md,
                        output logic [32*OW-1:0] od, output logic [1:0] osz);
    int n;
    c_idata = packi(x); c_isize = sz; c_imode = md; c_oready = 1'b0; c_ivalid = 1'b1;
    tick();
    c_ivalid = 1'b0;
    c_idata  = {24{$urandom}};
    n = 0;
    while (!c_ovalid && n < 8) begin tick(); n++; end
    checks++;
    if (c_ovalid !== 1'b1) begin
      errors++; $display("FAIL xfer_c_valid: o_valid=%b required 1", c_ovalid);
    end
    od = c_odata; osz = c_osize;
    c_oready = 1'b1;
    tick();
    c_oready = 1'b0;
  endtask

  task automatic xfer_b(input longint x[32], input logic [1:0] sz, input bit md,
                        output logic [8*OW-1:0] od, output logic [1:0] osz);
    logic [32*IW-1:0] pi;
    int n;
    pi = packi(x);
    b_idata = pi[8*IW-1:0]; b_isize = sz; b_imode = md; b_oready = 1'b0; b_ivalid = 1'b1;
    tick();
    b_ivalid = 1'b0;
    n = 0;
    while (!b_ovalid && n < 8) begin tick(); n++; end
    checks++;
    if (b_ovalid !== 1'b1) begin
      errors++; $display("FAIL xfer_b_valid: o_valid=%b required 1", b_ovalid);
    end
    od = b_odata; osz = b_osize;
    b_oready = 1'b1;
    tick();
    b_oready = 1'b0;
  endtask

  task automatic test_reset();
    longint x[32], y[32];
    logic [32*IW-1:0] pi;
    logic [32*OW-1:0] po;
    for (int k = 0; k < 32; k++) x[k] = rnd_s();
    pi = packi(x);
    rst = 1'b1; b_ivalid = 1'b1; b_idata = pi[8*IW-1:0]; b_isize = 2'd1; b_imode = 1'b0; b_oready = 1'b1;
    tick(); tick();
    checks++;
    if (b_ovalid !== 1'b0 || a_ovalid !== 1'b0 || c_ovalid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: o_valid a/b/c=%b%b%b required 000", a_ovalid, b_ovalid, c_ovalid);
    end
    checks++;
    if (b_odata !== '0 || b_osize !== 2'd0) begin
      errors++; $display("FAIL reset_data: o_data=%h o_size=%0d required 0/0", b_odata, b_osize);
    end
    rst = 1'b0;
    tick();
    b_ivalid = 1'b0;
    repeat (LAT - 1) begin
      checks++;
      if (b_ovalid !== 1'b0) begin
        errors++; $display("FAIL first_latency_early: o_valid=%b required 0", b_ovalid);
      end
      tick();
    end
    model(8, x, 1, 1'b0, y);
    po = packo(y);
    checks++;
    if (b_ovalid !== 1'b1 || b_odata !== po[8*OW-1:0] || b_osize !== 2'd1) begin
      errors++; $display("FAIL first_vector: valid=%b data=%h size=%0d required 1 %h 1",
                         b_ovalid, b_odata, b_osize, po[8*OW-1:0]);
    end
    tick();
    b_oready = 1'b0;
  endtask

  task automatic test_legacy4();
    logic [4*OW-1:0] expv;
    int n;
    a_idata = {24'sd7, -24'sd5, 24'sd3, 24'sd10};
    a_isize = 2'd0; a_imode = 1'b0; a_oready = 1'b0; a_ivalid = 1'b1;
    tick();
    a_ivalid = 1'b0;
    n = 0;
    while (!a_ovalid && n < 8) begin tick(); n++; end
    expv = {25'sd3, 25'sd8, -25'sd2, 25'sd17};
    checks++;
    if (a_ovalid !== 1'b1 || a_odata !== expv) begin
      errors++; $display("FAIL legacy4: valid=%b data=%h required 1 %h", a_ovalid, a_odata, expv);
    end
    a_oready = 1'b1;
    tick();
    a_oready = 1'b0;
  endtask

  task automatic test_extremes();
    longint x[32];
    logic [32*OW-1:0] od;
    logic [1:0] osz;
    for (int k = 0; k < 32; k++) x[k] = 0;
    x[0] = 8388607; x[31] = 8388607; x[1] = -8388608; x[30] = 8388607;
    xfer_c(x, 2'd3, 1'b0, od, osz);
    checks++;
    if (od[0*OW +: OW] !== 25'(16777214)) begin
      errors++; $display("FAIL ext_o0: got %0d required 16777214", $signed(od[0*OW +: OW]));
    end
    checks++;
    if (od[31*OW +: OW] !== 25'(0)) begin
      errors++; $display("FAIL ext_o31: got %0d required 0", $signed(od[31*OW +: OW]));
    end
    checks++;
    if (od[1*OW +: OW] !== 25'(-1)) begin
      errors++; $display("FAIL ext_o1: got %0d required -1", $signed(od[1*OW +: OW]));
    end
    checks++;
    if (od[30*OW +: OW] !== 25'(-16777215)) begin
      errors++; $display("FAIL ext_o30: got %0d required -16777215", $signed(od[30*OW +: OW]));
    end
  endtask

  task automatic test_segments();
    longint x[32], e[32];
    logic [32*OW-1:0] od, expv;
    logic [1:0] osz;
    for (int k = 0; k < 32; k++) x[k] = k;
    for (int b = 0; b < 32; b += 8)
      for (int k = 0; k < 4; k++) begin
        e[b+k]   = 2*b + 7;
        e[b+7-k] = 2*k - 7;
      end
    expv = packo(e);
    xfer_c(x, 2'd1, 1'b0, od, osz);
    checks++;
    if (od !== expv || osz !== 2'd1) begin
      errors++; $display("FAIL segments8: data=%h size=%0d required %h 1", od, osz, expv);
    end
  endtask

  task automatic test_clamp();
    longint x[32], y[32];
    logic [8*OW-1:0] od;
    logic [32*OW-1:0] po;
    logic [1:0] osz;
    for (int s = 2; s <= 3; s++) begin
      for (int k = 0; k < 32; k++) x[k] = rnd_s();
      model(8, x, 1, 1'b0, y);
      po = packo(y);
      xfer_b(x, 2'(s), 1'b0, od, osz);
      checks++;
      if (od !== po[8*OW-1:0] || osz !== 2'(s)) begin
        errors++; $display("FAIL clamp_size%0d: data=%h size=%0d required %h %0d", s, od, osz, po[8*OW-1:0], s);
      end
    end
  endtask

  task automatic test_mode();
    longint x[32];
    logic [8*OW-1:0] od;
    logic [32*OW-1:0] po;
    logic [1:0] osz;
    for (int k = 0; k < 32; k++) x[k] = (k < 8) ? rnd_s() : 0;
    x[0] = -1; x[1] = 2;
    po = packo(x);
    xfer_b(x, 2'd2, 1'b1, od, osz);
    checks++;
    if (od !== po[8*OW-1:0] || osz !== 2'd2) begin
      errors++; $display("FAIL mode_pass: data=%h size=%0d required %h 2", od, osz, po[8*OW-1:0]);
    end
  endtask

  task automatic test_random32();
    longint x[32], y[32];
    logic [32*OW-1:0] od, po;
    logic [1:0] osz, sz;
    bit md;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 32; k++) x[k] = rnd_s();
      sz = 2'($urandom_range(0, 3));
      md = ($urandom_range(0, 3) == 0);
      model(32, x, int'(sz), md, y);
      po = packo(y);
      xfer_c(x, sz, md, od, osz);
      checks++;
      if (od !== po || osz !== sz) begin
        errors++; $display("FAIL random32_%0d: size=%0d mode=%0d data=%h required %h", t, osz, md, od, po);
      end
    end
  endtask

  task automatic run_stream_b(input int nvec, input int ready_pct, output int cycles);
    longint x[32], y[32];
    logic [32*IW-1:0] pi;
    logic [32*OW-1:0] po;
    logic [8*OW-1:0] q[$];
    logic [1:0] qs[$];
    logic [8*OW-1:0] held;
    logic [1:0] held_sz, sz;
    bit held_v, md;
    int sent;
    sent = 0; cycles = 0; held_v = 0; held = '0; held_sz = '0;
    for (int k = 0; k < 32; k++) x[k] = rnd_s();
    sz = 2'($urandom_range(0, 3)); md = $urandom_range(0, 1) == 1;
    while (1) begin
      if (sent == nvec && q.size() == 0 && !b_ovalid) break;
      if (cycles >= nvec * 20 + 50) begin
        errors++; checks++;
        $display("FAIL stream_timeout: sent=%0d pending=%0d required all drained", sent, q.size());
        break;
      end
      if (held_v) begin
        checks++;
        if (b_ovalid !== 1'b1 || b_odata !== held || b_osize !== held_sz) begin
          errors++; $display("FAIL stall_hold: valid=%b data=%h required 1 %h", b_ovalid, b_odata, held);
        end
      end
      b_oready = ($urandom_range(1, 100) <= ready_pct);
      b_ivalid = (sent < nvec);
      pi = packi(x);
      b_idata = pi[8*IW-1:0]; b_isize = sz; b_imode = md;
      #1;
`ifndef BUTTERFLY_N_PIPE2_EN
      checks++;
      if (b_iready !== (!b_ovalid || b_oready)) begin
        errors++; $display("FAIL i_ready_rule: i_ready=%b required %b", b_iready, !b_ovalid || b_oready);
      end
`endif
      if (b_ovalid && b_oready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected output %h required none", b_odata);
        end else begin
          if (b_odata !== q[0] || b_osize !== qs[0]) begin
            errors++; $display("FAIL stream_data: data=%h size=%0d required %h %0d", b_odata, b_osize, q[0], qs[0]);
          end
          void'(q.pop_front()); void'(qs.pop_front());
        end
      end
      held_v = b_ovalid && !b_oready;
      held = b_odata; held_sz = b_osize;
      if (b_ivalid && b_iready) begin
        model(8, x, int'(sz), md, y);
        po = packo(y);
        q.push_back(po[8*OW-1:0]); qs.push_back(sz);
        sent++;
        for (int k = 0; k < 32; k++) x[k] = rnd_s();
        sz = 2'($urandom_range(0, 3)); md = $urandom_range(0, 1) == 1;
      end
      tick();
      cycles++;
    end
    b_ivalid = 1'b0; b_oready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_stream_b(8, 100, cyc);
    checks++;
    if (cyc !== 8 + LAT) begin
      errors++; $display("FAIL back_to_back_cycles: got %0d required %0d", cyc, 8 + LAT);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    run_stream_b(20, 50, cyc);
  endtask

  task automatic test_midflight_reset();
    longint x[32];
    logic [32*IW-1:0] pi;
    int n, seen;
    for (int k = 0; k < 32; k++) x[k] = rnd_s();
    pi = packi(x);
    b_oready = 1'b0; b_idata = pi[8*IW-1:0]; b_isize = 2'd0; b_imode = 1'b0; b_ivalid = 1'b1;
    tick();
    b_ivalid = 1'b0;
    n = 0;
    while (!b_ovalid && n < 8) begin tick(); n++; end
    tick();
    checks++;
    if (b_ovalid !== 1'b1) begin
      errors++; $display("FAIL midreset_setup: o_valid=%b required 1", b_ovalid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (b_ovalid !== 1'b0 || b_odata !== '0) begin
      errors++; $display("FAIL midreset_clear: valid=%b data=%h required 0 0", b_ovalid, b_odata);
    end
    b_oready = 1'b1;
    seen = 0;
    repeat (4) begin tick(); if (b_ovalid) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset_drop: outputs after reset=%0d required 0", seen);
    end
    b_oready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_ivalid = 0; a_isize = 0; a_imode = 0; a_idata = '0; a_oready = 0;
    b_ivalid = 0; b_isize = 0; b_imode = 0; b_idata = '0; b_oready = 0;
    c_ivalid = 0; c_isize = 0; c_imode = 0; c_idata = '0; c_oready = 0;
    #2;
    test_reset();
    test_legacy4();
    test_extremes();
    test_segments();
    test_clamp();
    test_mode();
    test_random32();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
